// File: rtl/oled_spi_rx.sv
// Receiving end of the OLED 4-wire SPI link: oversamples cs/sclk/sdin/dc in the clk
// domain, deserialises MSB-first bytes tagged with D/C, and queues them in a FWFT FIFO.
module oled_spi_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             sclk,
    input  logic             sdin,
    input  logic             dc,
    output logic [7:0]       rx_data,
    output logic             rx_dc,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] byte_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic r_csS1, r_csS2, r_csHist;
    logic r_sclkS1, r_sclkS2, r_sclkHist;
    logic r_sdinS1, r_sdinS2;
    logic r_dcS1, r_dcS2;

    logic [0:0]       r_state;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic             r_pushPending;
    logic [8:0]       r_pushEntry;
    logic             r_frameErr;
    logic             r_overflow;
    logic [CNT_W-1:0] r_byteCount;

    logic [8:0]       r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;

    logic w_sclkRise;
    logic w_csRise;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_pushOk;

    assign w_sclkRise = r_sclkS2 & ~r_sclkHist;
    assign w_csRise   = r_csS2 & ~r_csHist;

    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop    = rx_valid && rx_ready;
    assign w_pushOk = r_pushPending && (!w_full || w_pop);

    assign rx_valid   = ~w_empty;
    assign rx_data    = r_mem[r_rdPtr[AW-1:0]][7:0];
    assign rx_dc      = r_mem[r_rdPtr[AW-1:0]][8];
    assign overflow   = r_overflow;
    assign frame_err  = r_frameErr;
    assign byte_count = r_byteCount;

    // Synchronisers reset to the idle line levels so no false edge appears after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csS1     <= 1'b1;
            r_csS2     <= 1'b1;
            r_csHist   <= 1'b1;
            r_sclkS1   <= 1'b1;
            r_sclkS2   <= 1'b1;
            r_sclkHist <= 1'b1;
            r_sdinS1   <= 1'b0;
            r_sdinS2   <= 1'b0;
            r_dcS1     <= 1'b0;
            r_dcS2     <= 1'b0;
        end else begin
            r_csS1     <= cs;
            r_csS2     <= r_csS1;
            r_csHist   <= r_csS2;
            r_sclkS1   <= sclk;
            r_sclkS2   <= r_sclkS1;
            r_sclkHist <= r_sclkS2;
            r_sdinS1   <= sdin;
            r_sdinS2   <= r_sdinS1;
            r_dcS1     <= dc;
            r_dcS2     <= r_dcS1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bitCnt      <= 3'd0;
            r_shift       <= 8'd0;
            r_pushPending <= 1'b0;
            r_pushEntry   <= 9'd0;
            r_frameErr    <= 1'b0;
        end else begin
            r_pushPending <= 1'b0;
            r_frameErr    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bitCnt <= 3'd0;
                    if (!r_csS2) begin
                        r_state <= ST_SHIFT;
                    end
                end
                default: begin
                    // cs release wins over a coincident sclk rise
                    if (w_csRise) begin
                        r_frameErr <= (r_bitCnt != 3'd0);
                        r_bitCnt   <= 3'd0;
                        r_state    <= ST_IDLE;
                    end else if (w_sclkRise) begin
                        r_shift  <= {r_shift[6:0], r_sdinS2};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_pushPending <= 1'b1;
                            r_pushEntry   <= {r_dcS2, r_shift[6:0], r_sdinS2};
                        end
                    end
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_overflow  <= 1'b0;
            r_byteCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 9'd0;
            end
        end else begin
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pushOk) begin
                r_mem[r_wrPtr[AW-1:0]] <= r_pushEntry;
                r_wrPtr                <= r_wrPtr + 1'b1;
                r_byteCount            <= r_byteCount + 1'b1;
            end else if (r_pushPending) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Scenario bench for oled_spi_rx: drives SPI frames from tasks, checks the popped
// stream against a queue of expected {dc,data} entries, plus flag/counter checks.
module tb_oled_spi_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs = 1'b1;
    logic        sclk = 1'b1;
    logic        sdin = 1'b0;
    logic        dc = 1'b0;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_dc;
    logic        rx_valid;
    logic        overflow;
    logic        frame_err;
    logic [15:0] byte_count;

    int checks = 0;
    int passes = 0;
    int popCount = 0;
    int ferrPulses = 0;
    int ferrRun = 0;
    int ferrMaxRun = 0;
    logic [8:0] expQ[$];

    oled_spi_rx #(.DEPTH(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sclk       (sclk),
        .sdin       (sdin),
        .dc         (dc),
        .rx_data    (rx_data),
        .rx_dc      (rx_dc),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so the negedge sees what the next posedge will use
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) begin
                checks++;
                popCount++;
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL pop_unexpected: got dc=%0b data=%02h, required no entry", rx_dc, rx_data);
                end else begin
                    logic [8:0] e;
                    e = expQ.pop_front();
                    if ({rx_dc, rx_data} !== e)
                        $display("[TB] FAIL pop_data: got dc=%0b data=%02h, required dc=%0b data=%02h",
                                 rx_dc, rx_data, e[8], e[7:0]);
                    else
                        passes++;
                end
            end
            if (frame_err === 1'b1) begin
                if (ferrRun == 0) ferrPulses++;
                ferrRun++;
                if (ferrRun > ferrMaxRun) ferrMaxRun = ferrRun;
            end else begin
                ferrRun = 0;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cs = 1'b1;
        sclk = 1'b1;
        sdin = 1'b0;
        dc = 1'b0;
        rx_ready = 1'b0;
        tick(2);
        expQ.delete();
        rst = 1'b0;
        tick(2);
    endtask

    task automatic sendBit(input logic b);
        sdin = b;
        sclk = 1'b0;
        tick(8);
        sclk = 1'b1;
        tick(8);
    endtask

    task automatic sendBits(input logic [7:0] data, input logic dcv, input int n);
        logic [7:0] d;
        d = data;
        dc = dcv;
        for (int i = 7; i > 7 - n; i--) sendBit(d[i]);
    endtask

    task automatic expectEq(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
        else passes++;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if ({rx_valid, rx_data, rx_dc, overflow, frame_err} !== 12'd0 || byte_count !== 16'd0)
            $display("[TB] FAIL reset_outputs: got valid=%0b data=%02h dc=%0b ovf=%0b ferr=%0b cnt=%0d, required all 0",
                     rx_valid, rx_data, rx_dc, overflow, frame_err, byte_count);
        else passes++;
    endtask

    task automatic test_command();
        logic [7:0] b;
        b = 8'hAF;
        doReset();
        cs = 1'b0;
        tick(4);
        sendBits(b, 1'b0, 7);
        expQ.push_back({1'b0, b});
        sdin = b[0];
        sclk = 1'b0;
        tick(8);
        sclk = 1'b1;
        tick(3);
        expectEq("cmd_valid_before_push", 16'(rx_valid), 16'd0);
        tick(1);
        expectEq("cmd_valid_after_push", 16'(rx_valid), 16'd1);
        expectEq("cmd_head", {7'd0, rx_dc, rx_data}, 16'h00AF);
        expectEq("cmd_count", byte_count, 16'd1);
        tick(4);
        cs = 1'b1;
        rx_ready = 1'b1;
        tick(4);
        expectEq("cmd_drained", 16'(rx_valid), 16'd0);
        expectEq("cmd_queue_left", 16'(expQ.size()), 16'd0);
    endtask

    task automatic test_back_to_back();
        int f0;
        doReset();
        f0 = ferrPulses;
        rx_ready = 1'b1;
        cs = 1'b0;
        tick(4);
        expQ.push_back({1'b0, 8'h15}); sendBits(8'h15, 1'b0, 8);
        expQ.push_back({1'b1, 8'h00}); sendBits(8'h00, 1'b1, 8);
        expQ.push_back({1'b1, 8'h5F}); sendBits(8'h5F, 1'b1, 8);
        tick(4);
        cs = 1'b1;
        tick(8);
        expectEq("b2b_count", byte_count, 16'd3);
        expectEq("b2b_queue_left", 16'(expQ.size()), 16'd0);
        expectEq("b2b_frame_err", 16'(ferrPulses - f0), 16'd0);
    endtask

    task automatic test_overflow();
        int p0;
        doReset();
        cs = 1'b0;
        tick(4);
        for (int i = 1; i <= 4; i++) begin
            expQ.push_back({1'b0, 8'(i)});
            sendBits(8'(i), 1'b0, 8);
        end
        tick(4);
        expectEq("ovf_before_5th", 16'(overflow), 16'd0);
        sendBits(8'h05, 1'b0, 8);
        tick(4);
        expectEq("ovf_after_5th", 16'(overflow), 16'd1);
        expectEq("ovf_count", byte_count, 16'd4);
        expectEq("ovf_head", {7'd0, rx_dc, rx_data}, 16'h0001);
        cs = 1'b1;
        p0 = popCount;
        rx_ready = 1'b1;
        tick(4);
        expectEq("ovf_pops", 16'(popCount - p0), 16'd4);
        expectEq("ovf_valid_fell", 16'(rx_valid), 16'd0);
        expectEq("ovf_sticky", 16'(overflow), 16'd1);
    endtask

    task automatic test_partial_frame();
        int f0;
        doReset();
        f0 = ferrPulses;
        ferrMaxRun = 0;
        rx_ready = 1'b1;
        cs = 1'b0;
        tick(4);
        sendBits(8'hFF, 1'b0, 5);
        cs = 1'b1;
        tick(10);
        expectEq("partial_ferr_pulses", 16'(ferrPulses - f0), 16'd1);
        expectEq("partial_ferr_width", 16'(ferrMaxRun), 16'd1);
        expectEq("partial_no_push", byte_count, 16'd0);
        cs = 1'b0;
        tick(4);
        expQ.push_back({1'b0, 8'h3C});
        sendBits(8'h3C, 1'b0, 8);
        tick(4);
        cs = 1'b1;
        tick(8);
        expectEq("partial_next_count", byte_count, 16'd1);
        expectEq("partial_next_queue", 16'(expQ.size()), 16'd0);
        expectEq("partial_silent_close", 16'(ferrPulses - f0), 16'd1);
    endtask

    task automatic test_simultaneous();
        int p0;
        logic [7:0] b;
        b = 8'h14;
        doReset();
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({1'b1, 8'h10 + 8'(i)});
            sendBits(8'h10 + 8'(i), 1'b1, 8);
        end
        expQ.push_back({1'b1, b});
        sendBits(b, 1'b1, 7);
        sdin = b[0];
        sclk = 1'b0;
        tick(8);
        sclk = 1'b1;
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(4);
        expectEq("simul_overflow", 16'(overflow), 16'd0);
        expectEq("simul_count", byte_count, 16'd5);
        expectEq("simul_head", {7'd0, rx_dc, rx_data}, 16'h0111);
        cs = 1'b1;
        p0 = popCount;
        rx_ready = 1'b1;
        tick(6);
        expectEq("simul_occupancy", 16'(popCount - p0), 16'd4);
        expectEq("simul_queue_left", 16'(expQ.size()), 16'd0);
    endtask

    task automatic test_mid_reset();
        int f0;
        doReset();
        cs = 1'b0;
        tick(4);
        sendBits(8'hE7, 1'b1, 3);
        f0 = ferrPulses;
        rst = 1'b1;
        tick(2);
        checks++;
        if ({rx_valid, rx_data, rx_dc, overflow, frame_err} !== 12'd0 || byte_count !== 16'd0)
            $display("[TB] FAIL midrst_outputs: got valid=%0b data=%02h dc=%0b ovf=%0b ferr=%0b cnt=%0d, required all 0",
                     rx_valid, rx_data, rx_dc, overflow, frame_err, byte_count);
        else passes++;
        rst = 1'b0;
        tick(4);
        rx_ready = 1'b1;
        expQ.push_back({1'b1, 8'hA0});
        sendBits(8'hA0, 1'b1, 8);
        tick(4);
        cs = 1'b1;
        tick(8);
        expectEq("midrst_count", byte_count, 16'd1);
        expectEq("midrst_queue_left", 16'(expQ.size()), 16'd0);
        expectEq("midrst_no_ferr", 16'(ferrPulses - f0), 16'd0);
    endtask

    initial begin
        test_reset();
        test_command();
        test_back_to_back();
        test_overflow();
        test_partial_frame();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Serial-side capture model of the OLED panel's 4-wire SPI interface. It is the receiving end of the link driven by the OLED controller on cs/sclk/sdin/dc.
- Oversamples the controller's pins in the `clk` domain and deserialises MSB-first bytes. Each byte is tagged with its D/C flag and pushed into a small FIFO with a valid/ready output.
- Used in simulation benches, and optionally in hardware, to check the command and pixel streams produced by the OLED top level.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, ≥2.
- CNT_W, 16, width of the received-byte counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  SPI chip select, active low; asynchronous to clk.
- sclk  input  1  SPI clock; data is sampled on its rising edge. Asynchronous to clk.
- sdin  input  1  SPI data, MSB first.
- dc  input  1  data/command select (0 = command, 1 = data); asynchronous to clk.
- rx_data  output  8  byte at FIFO head.
- rx_dc  output  1  D/C flag of the byte at FIFO head.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts the head entry when rx_valid && rx_ready.
- overflow  output  1  sticky: a completed byte was dropped because the FIFO was full.
- frame_err  output  1  one-cycle pulse: cs deasserted with a partial byte captured.
- byte_count  output  CNT_W  number of bytes successfully pushed since reset.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - On rst: rx_valid=0, rx_data=0, rx_dc=0, overflow=0, frame_err=0, byte_count=0. FIFO is emptied, bit counter and shift register are cleared, and synchroniser stages are loaded with the idle values cs=1, sclk=1, sdin=0, dc=0.
- Input synchronisation:
  - cs, sclk, sdin and dc each pass through a 2-FF synchroniser, followed by one history register for cs and sclk.
  - An sclk rise is detected when sync2=1 and hist=0. Detection latency is 3 clk cycles after the pin edge.
  - Input timing requirement: sclk high and low phases ≥3 clk periods each; sdin/dc setup to sclk rise ≥2 clk periods.
- Capture states:
  - IDLE: synced cs=1. Bit counter is held at 0 and sclk edges are ignored. Transitions to SHIFT when synced cs=0.
  - SHIFT: on each detected sclk rise, shift = {shift[6:0], sdin_sync} and bit_cnt increments.
  - On the 8th rise, the completed byte and the synced dc at that same edge form one entry, and bit_cnt wraps to 0. cs may stay low across consecutive bytes, so no return to IDLE is needed between bytes.
  - A synced cs rising edge while bit_cnt≠0: frame_err=1 for exactly one cycle, the partial byte is discarded, bit_cnt=0, state returns to IDLE.
  - A synced cs rising edge while bit_cnt=0: returns to IDLE silently.
- Push:
  - The push occurs in the cycle after the 8th edge is detected.
  - If the FIFO is not full, or a pop occurs in the same cycle, the entry is written and byte_count increments. byte_count wraps modulo 2^CNT_W.
  - If the FIFO is full and there is no pop, the byte is dropped, overflow is set and held until rst, and byte_count is unchanged.
- FIFO:
  - First-word fall-through. rx_data/rx_dc are driven from the head entry.
  - rx_valid rises the cycle after a push into an empty FIFO.
  - A pop (rx_valid && rx_ready) advances the head the next cycle.
  - Simultaneous push and pop keeps the occupancy unchanged.
  - rx_data/rx_dc hold their last value when the FIFO is empty (don't care).
- Reset mid-byte: the partial byte is lost and there is no frame_err pulse. The next capture starts from bit 0 when cs is next low.

Test Plan:
1. Command byte: with cs low and dc=0, shift 0xAF at 16 clk per sclk period → one entry rx_data=0xAF, rx_dc=0. rx_valid rises 1 cycle after the push and byte_count=1.
2. Back-to-back bytes with cs held low: 0x15 (dc=0), then 0x00, 0x5F (dc=1), rx_ready=1 → three entries in order with rx_dc 0,1,1, byte_count=3, no frame_err.
3. Backpressure/overflow with DEPTH=4: rx_ready=0, send 5 bytes 0x01..0x05 → 4 entries held, overflow=1 after the 5th byte, byte_count=4. Then rx_ready=1 → pops 0x01..0x04, and rx_valid falls after the 4th pop.
4. Partial frame: send 5 bits of 0xFF, then raise cs → frame_err pulses for exactly 1 cycle and no push. A following full byte 0x3C is received intact.
5. Simultaneous push/pop with the FIFO full and rx_ready=1 at the push cycle → the new byte is accepted, overflow stays 0, occupancy stays 4.
6. Reset mid-byte: assert rst after 3 bits of a byte → all outputs return to their reset values. A subsequent byte 0xA0 is received correctly with byte_count=1.
